// File: rtl/commutator4_sdf_if.sv
// Stream bus of the radix-4 commutator: framing/mode controls and four packed
// lanes in, transposed lanes plus valid/frame-done out.
interface commutator4_sdf_if #(
  parameter int NB = 16
);
  logic            start;
  logic            bypass;
  logic            in_valid;
  logic [4*NB-1:0] input_data;
  logic [4*NB-1:0] output_data;
  logic            out_valid;
  logic            done;

  modport master (
    output start, bypass, in_valid, input_data,
    input  output_data, out_valid, done
  );

  modport slave (
    input  start, bypass, in_valid, input_data,
    output output_data, out_valid, done
  );
endinterface

// File: rtl/commutator4_sdf.sv
// Radix-4 SDF commutator: streaming 4x4 block transpose of `stage`-deep blocks
// across four lanes, with valid stall, start alignment and latched bypass.
module commutator4_sdf #(
  parameter int nb    = 16,
  parameter int stage = 2
) (
  input logic               clk,
  input logic               reset_n,
  commutator4_sdf_if.slave  bus
);
  localparam int FRAME  = 4 * stage;
  localparam int FILL   = 3 * stage;
  localparam int PH_W   = $clog2(FRAME);
  localparam int FILL_W = $clog2(FILL + 1);

  logic [PH_W-1:0]   ph_q, ph_d, idx;
  logic [FILL_W-1:0] fill_q, fill_d, fill_cur;
  logic              byp_q, byp_d, byp_cur;
  logic              accept, primed;
  logic [1:0]        blk;

  logic [3:0][nb-1:0] lane_in, in_del, sw, post;

  logic [4*nb-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            done_q, done_d;

  assign accept  = bus.in_valid;
  assign lane_in = bus.input_data;

  // start overrides the stored phase/fill/mode for the beat it coincides with
  always_comb begin
    idx      = bus.start ? '0 : ph_q;
    fill_cur = bus.start ? '0 : fill_q;
    byp_cur  = bus.start ? bus.bypass : byp_q;
    primed   = (fill_cur == FILL_W'(FILL));
    blk      = 2'(int'(idx) / stage);
  end

  always_comb begin
    ph_d   = idx;
    fill_d = fill_cur;
    byp_d  = byp_cur;
    if (accept) begin
      ph_d   = (idx == PH_W'(FRAME - 1)) ? '0 : idx + 1'b1;
      fill_d = primed ? fill_cur : fill_cur + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q   <= '0;
      fill_q <= '0;
      byp_q  <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      fill_q <= fill_d;
      byp_q  <= byp_d;
    end
  end

  // input skew: lane gi delayed gi*stage accepted beats
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_in
      if (gi == 0) begin : g_wire
        assign in_del[gi] = lane_in[gi];
      end else begin : g_dly
        logic [nb-1:0] sr_q [gi*stage];
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            for (int k = 0; k < gi*stage; k++) sr_q[k] <= '0;
          end else if (accept) begin
            sr_q[0] <= lane_in[gi];
            for (int k = 1; k < gi*stage; k++) sr_q[k] <= sr_q[k-1];
          end
        end
        assign in_del[gi] = sr_q[gi*stage-1];
      end
    end
  endgenerate

  always_comb begin
    for (int j = 0; j < 4; j++) sw[j] = in_del[2'(blk - 2'(j))];
  end

  // output deskew: lane gi delayed (3-gi)*stage accepted beats
  generate
    for (gi = 0; gi < 4; gi++) begin : g_out
      if (gi == 3) begin : g_wire
        assign post[gi] = sw[gi];
      end else begin : g_dly
        logic [nb-1:0] sr_q [(3-gi)*stage];
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            for (int k = 0; k < (3-gi)*stage; k++) sr_q[k] <= '0;
          end else if (accept) begin
            sr_q[0] <= sw[gi];
            for (int k = 1; k < (3-gi)*stage; k++) sr_q[k] <= sr_q[k-1];
          end
        end
        assign post[gi] = sr_q[(3-gi)*stage-1];
      end
    end
  endgenerate

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    if (accept) begin
      if (byp_cur) begin
        out_data_d  = bus.input_data;
        out_valid_d = 1'b1;
        done_d      = (idx == PH_W'(FRAME - 1));
      end else begin
        out_data_d  = post;
        out_valid_d = primed;
        // last output beat of a frame lags its input beat by 3*stage
        done_d      = primed && (idx == PH_W'(FILL - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.output_data = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_commutator4_sdf.sv
// Directed bench for commutator4_sdf (nb=16, stage=2): transpose, frames,
// stalls, mid-frame start, bypass and asynchronous reset.
module tb_commutator4_sdf;
  localparam int NB = 16;
  localparam int D  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  commutator4_sdf_if #(.NB(NB)) bus ();

  commutator4_sdf #(.nb(NB), .stage(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lanes_in(input int a);
    return {16'(48 + a), 16'(32 + a), 16'(16 + a), 16'(a)};
  endfunction

  // output beat u=a-3D: lane j = input lane u/D, block j, offset u%D
  function automatic logic [63:0] lanes_exp(input int a);
    int u, f, uu;
    logic [63:0] v;
    u  = a - 3*D;
    f  = u / (4*D);
    uu = u % (4*D);
    v  = '0;
    for (int j = 0; j < 4; j++)
      v[16*j +: 16] = 16'(16*(uu/D) + 4*D*f + D*j + (uu%D));
    return v;
  endfunction

  task automatic stream(input int n, input int stall_pct, input bit use_start);
    int a = 0;
    int cycles = 0;
    bit valid;
    logic [63:0] prev;
    while (a < n && cycles < 2000) begin
      valid = (a == 0) || ($urandom_range(99) >= stall_pct);
      bus.in_valid   = valid;
      bus.start      = use_start && (a == 0);
      bus.bypass     = 1'b0;
      bus.input_data = lanes_in(a);
      prev = bus.output_data;
      @(posedge clk); #1;
      cycles++;
      if (valid) begin
        $display("beat a=%0d ov=%0b done=%0b data=%h", a, bus.out_valid, bus.done, bus.output_data);
        check("out_valid", 64'(bus.out_valid), 64'(a >= 3*D));
        check("done", 64'(bus.done), 64'((a >= 3*D) && ((a - 3*D) % (4*D) == 4*D - 1)));
        if (a >= 3*D) check("data", bus.output_data, lanes_exp(a));
        a++;
      end else begin
        $display("stall after a=%0d ov=%0b done=%0b", a, bus.out_valid, bus.done);
        check("stall_valid", 64'(bus.out_valid), 64'd0);
        check("stall_done", 64'(bus.done), 64'd0);
        check("stall_hold", bus.output_data, prev);
      end
    end
    check("stream_timeout", 64'(a), 64'(n));
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic bypass_run(input int n, input bit do_start, input bit byp_val, input int base);
    int a = 0;
    int cycles = 0;
    bit valid;
    logic [63:0] din, prev;
    while (a < n && cycles < 100) begin
      valid = (cycles != 3);
      din = {4{16'(16'h1234 + a + base)}};
      bus.in_valid   = valid;
      bus.start      = do_start && (cycles == 0);
      bus.bypass     = byp_val;
      bus.input_data = din;
      prev = bus.output_data;
      @(posedge clk); #1;
      cycles++;
      $display("bypass k=%0d v=%0b ov=%0b done=%0b data=%h", a + base, valid, bus.out_valid, bus.done, bus.output_data);
      if (valid) begin
        check("byp_valid", 64'(bus.out_valid), 64'd1);
        check("byp_data", bus.output_data, din);
        check("byp_done", 64'(bus.done), 64'(((a + base) % (4*D)) == 4*D - 1));
        a++;
      end else begin
        check("byp_stall_valid", 64'(bus.out_valid), 64'd0);
        check("byp_stall_hold", bus.output_data, prev);
      end
    end
    check("bypass_timeout", 64'(a), 64'(n));
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.bypass     = 1'b0;
    bus.in_valid   = 1'b0;
    bus.input_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_data", bus.output_data, 64'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    stream(48, 0, 1'b1);   // identity + five contiguous frames
    stream(40, 50, 1'b1);  // random stalls
    stream(19, 0, 1'b1);   // runs into frame 2, beat 3
    stream(24, 0, 1'b1);   // mid-frame restart
    bypass_run(8, 1'b1, 1'b1, 0);
    bypass_run(8, 1'b0, 1'b0, 8);  // bypass toggled without start
    stream(10, 0, 1'b1);

    bus.in_valid = 1'b1;
    bus.input_data = lanes_in(10);
    #3 reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_data", bus.output_data, 64'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    stream(24, 0, 1'b0);   // first beat after release is beat 0

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
